traffic_seq_ctrl: RTL and testbench
===================================

Name: traffic_seq_ctrl

Overview:
Parametrised, synthesizable traffic sequencer for the interconnect device. It holds the device in reset, programs the FIFO thresholds, then pushes a generated data stream into the main FIFO. The stream respects MAIN_FIFO_pause. The block also drives per-destination pops from the almost_empty flags. It replaces the fixed bench stimulus with N destinations, selectable data pattern, configurable run/drain lengths and push accounting.

Parameters:
DATA_W, 6, width of data_in words
PTR_L, 5, width of each FIFO threshold
N_DEST, 2, number of destination FIFOs (pop/almost_empty lanes)
HOLD_CYC, 10, cycles dut_reset_n is held low after start
RUN_LEN, 50, RUN-state length in cycles
DRAIN_LEN, 50, DRAIN-state length in cycles
CNT_W, 16, width of sent_count

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  begin a sequence (sampled in IDLE or DONE)
abort  in  1  return to IDLE from any state
mode  in  1  0 = incrementing pattern, 1 = LFSR pattern
seed  in  16  pattern seed
pop_enable  in  1  global pop gate
cfg_M_full, cfg_M_empty, cfg_V_full, cfg_V_empty, cfg_D_full, cfg_D_empty  in  PTR_L each  threshold values to program
MAIN_FIFO_pause  in  1  backpressure from the main FIFO
almost_empty  in  N_DEST  per-destination almost-empty flags
dut_reset_n  out  1  reset to the device under control, active-low
umbral_M_full, umbral_M_empty, umbral_V_full, umbral_V_empty, umbral_D_full, umbral_D_empty  out  PTR_L each  registered thresholds
data_in  out  DATA_W  data word to the main FIFO
push_data_in  out  1  push strobe
pop_D  out  N_DEST  per-destination pop
sent_count  out  CNT_W  accepted pushes in the current sequence
busy  out  1  state is not IDLE or DONE
done  out  1  state is DONE

Behaviour:
- Reset (reset=1 at clk edge) forces the following:
  - state=IDLE, dut_reset_n=0, all umbral_*=0, data_in=0, push_data_in=0, sent_count=0, busy=0, done=0.
  - LFSR = 16'hACE1; incrementing counter = 0.
  - Reset mid-sequence aborts immediately with the same values.
- States: IDLE, HOLD, CONFIG, RUN, DRAIN, DONE. State and all outputs except pop_D are registered.
- IDLE: dut_reset_n=0.
  - start=1 -> HOLD.
  - On that edge: sent_count cleared; counter loaded with seed[DATA_W-1:0]; LFSR loaded with seed (seed==0 loads 16'hACE1).
- HOLD: dut_reset_n=0 for exactly HOLD_CYC cycles -> CONFIG.
- CONFIG: one cycle.
  - dut_reset_n=1.
  - All umbral_* loaded from cfg_* on the CONFIG edge, so visible from the first RUN cycle.
  - cfg_* are ignored at all other times; umbral_* hold until the next CONFIG or reset.
  - -> RUN.
- RUN: exactly RUN_LEN cycles, decided per cycle from the MAIN_FIFO_pause value sampled at each edge.
  - pause=0: next cycle push_data_in=1, data_in=current pattern value; pattern advances; sent_count+1 (saturates at all-ones).
  - pause=1: next cycle push_data_in=0, data_in=0; pattern holds.
- Pattern rules:
  - mode 0: counter value, +1 modulo 2^DATA_W (wraps all-ones -> 0).
  - mode 1: data_in = LFSR[DATA_W-1:0]. Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), shifts right once per accepted push.
  - mode is sampled only on the start edge; later changes are ignored.
- DRAIN: exactly DRAIN_LEN cycles, push_data_in=0, data_in=0 -> DONE.
- DONE: done=1, outputs hold, sent_count frozen.
  - start=1 -> HOLD (new sequence; umbral_* reprogrammed in CONFIG).
- abort=1 in any state:
  - -> IDLE next edge; push_data_in=0, data_in=0, dut_reset_n=0.
  - umbral_* and sent_count retained.
  - abort takes priority over start.
- pop_D[i] (combinational from registered state):
  - = pop_enable & ~almost_empty[i] & (state==RUN or DRAIN); otherwise 0.
  - Lanes are independent; simultaneous pops on all lanes are allowed.
- Total sequence latency with pause=0: start edge -> push of the last word = HOLD_CYC+1+RUN_LEN cycles; done asserts DRAIN_LEN cycles later.

Test Plan:
- Defaults, mode=0, seed=16'h003E, pause=0 -> dut_reset_n low 10 cycles then high; data_in 3E,3F,00,01,... for 50 pushes; sent_count=50; done after 50 drain cycles.
- mode=0, seed=0, pause=1 on every 3rd RUN cycle -> no push on paused cycles; pattern resumes without gaps (0,1,2,3... in pushed words); sent_count = RUN_LEN minus paused cycles.
- mode=1, seed=0 -> first word = ACE1[5:0]=6'h21, following words match the reference LFSR model; a second sequence with seed=0 reproduces the same stream.
- cfg_M_full=3, cfg_V_full=15, cfg_D_full=3, all empties=1 -> umbral_* still 0 during HOLD, take the cfg values on the first RUN cycle, unchanged when cfg_* change later.
- almost_empty=2'b01, pop_enable=1 in RUN -> pop_D=2'b10; pop_enable=0 -> 2'b00; IDLE/DONE -> 2'b00 regardless of flags.
- reset=1 in the middle of RUN -> next cycle all outputs at reset values, state IDLE; abort in DRAIN -> IDLE, umbral_* and sent_count retained, start then re-runs from HOLD.

Source files
------------

// File: rtl/traffic_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_seq_ctrl_if
//  Purpose  : Main-FIFO push path and per-destination pop lanes of the
//             traffic sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface traffic_seq_ctrl_if #(
   parameter int DATA_W = 6,
   parameter int N_DEST = 2
);
   logic [DATA_W-1:0] data_in;
   logic              push_data_in;
   logic              MAIN_FIFO_pause;
   logic [N_DEST-1:0] almost_empty;
   logic [N_DEST-1:0] pop_D;

   modport master (
      output data_in, push_data_in, pop_D,
      input  MAIN_FIFO_pause, almost_empty
   );

   modport slave (
      input  data_in, push_data_in, pop_D,
      output MAIN_FIFO_pause, almost_empty
   );
endinterface
`default_nettype wire

// File: rtl/traffic_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_seq_ctrl
//  Purpose  : Holds the device in reset, programs FIFO thresholds, then
//             streams a counter/LFSR pattern into the main FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_seq_ctrl #(
   parameter int DATA_W    = 6,
   parameter int PTR_L     = 5,
   parameter int N_DEST    = 2,
   parameter int HOLD_CYC  = 10,
   parameter int RUN_LEN   = 50,
   parameter int DRAIN_LEN = 50,
   parameter int CNT_W     = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic                mode,
   input  logic [15:0]         seed,
   input  logic                pop_enable,
   input  logic [PTR_L-1:0]    cfg_M_full,
   input  logic [PTR_L-1:0]    cfg_M_empty,
   input  logic [PTR_L-1:0]    cfg_V_full,
   input  logic [PTR_L-1:0]    cfg_V_empty,
   input  logic [PTR_L-1:0]    cfg_D_full,
   input  logic [PTR_L-1:0]    cfg_D_empty,
   output logic                dut_reset_n,
   output logic [PTR_L-1:0]    umbral_M_full,
   output logic [PTR_L-1:0]    umbral_M_empty,
   output logic [PTR_L-1:0]    umbral_V_full,
   output logic [PTR_L-1:0]    umbral_V_empty,
   output logic [PTR_L-1:0]    umbral_D_full,
   output logic [PTR_L-1:0]    umbral_D_empty,
   output logic [CNT_W-1:0]    sent_count,
   output logic                busy,
   output logic                done,
   traffic_seq_ctrl_if.master  bus
);

   localparam int c_MAX_LEN = (HOLD_CYC > RUN_LEN) ?
                              ((HOLD_CYC > DRAIN_LEN) ? HOLD_CYC : DRAIN_LEN) :
                              ((RUN_LEN  > DRAIN_LEN) ? RUN_LEN  : DRAIN_LEN);
   localparam int c_CYC_W   = (c_MAX_LEN > 1) ? $clog2(c_MAX_LEN) : 1;

   localparam logic [c_CYC_W-1:0] c_HOLD_LAST  = c_CYC_W'(HOLD_CYC - 1);
   localparam logic [c_CYC_W-1:0] c_RUN_LAST   = c_CYC_W'(RUN_LEN - 1);
   localparam logic [c_CYC_W-1:0] c_DRAIN_LAST = c_CYC_W'(DRAIN_LEN - 1);
   localparam logic [15:0]        c_LFSR_INIT  = 16'hACE1;
   localparam logic [15:0]        c_LFSR_MASK  = 16'hB400;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HOLD   = 3'd1,
      S_CONFIG = 3'd2,
      S_RUN    = 3'd3,
      S_DRAIN  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t             r_state,  w_state;
   logic [c_CYC_W-1:0] r_cyc,    w_cyc;
   logic               r_mode,   w_mode;
   logic [DATA_W-1:0]  r_cnt,    w_cnt;
   logic [15:0]        r_lfsr,   w_lfsr;
   logic               r_dut_reset_n, w_dut_reset_n;
   logic [DATA_W-1:0]  r_data,   w_data;
   logic               r_push,   w_push;
   logic [CNT_W-1:0]   r_sent,   w_sent;
   logic               r_busy,   w_busy;
   logic               r_done,   w_done;
   logic [PTR_L-1:0]   r_mf, r_me, r_vf, r_ve, r_df, r_de;
   logic [PTR_L-1:0]   w_mf, w_me, w_vf, w_ve, w_df, w_de;

   logic               w_start_seq;
   logic [DATA_W-1:0]  w_pattern;
   logic [15:0]        w_lfsr_step;
   logic [15:0]        w_lfsr_seed;

   assign w_pattern   = r_mode ? r_lfsr[DATA_W-1:0] : r_cnt;
   assign w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_MASK : 16'h0000);
   // A zero seed would lock the LFSR, so it falls back to the reset value.
   assign w_lfsr_seed = (seed == 16'h0000) ? c_LFSR_INIT : seed;

   always_comb begin
      w_state       = r_state;
      w_cyc         = r_cyc;
      w_mode        = r_mode;
      w_cnt         = r_cnt;
      w_lfsr        = r_lfsr;
      w_dut_reset_n = r_dut_reset_n;
      w_data        = '0;
      w_push        = 1'b0;
      w_sent        = r_sent;
      w_mf          = r_mf;
      w_me          = r_me;
      w_vf          = r_vf;
      w_ve          = r_ve;
      w_df          = r_df;
      w_de          = r_de;
      w_start_seq   = 1'b0;

      if (abort) begin
         w_state       = S_IDLE;
         w_dut_reset_n = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_dut_reset_n = 1'b0;
               w_start_seq   = start;
            end
            S_HOLD: begin
               if (r_cyc == c_HOLD_LAST) begin
                  w_state       = S_CONFIG;
                  w_cyc         = '0;
                  w_dut_reset_n = 1'b1;
               end else begin
                  w_cyc = r_cyc + 1'b1;
               end
            end
            S_CONFIG: begin
               w_mf    = cfg_M_full;
               w_me    = cfg_M_empty;
               w_vf    = cfg_V_full;
               w_ve    = cfg_V_empty;
               w_df    = cfg_D_full;
               w_de    = cfg_D_empty;
               w_state = S_RUN;
               w_cyc   = '0;
            end
            S_RUN: begin
               if (!bus.MAIN_FIFO_pause) begin
                  w_push = 1'b1;
                  w_data = w_pattern;
                  w_cnt  = r_cnt + 1'b1;
                  w_lfsr = w_lfsr_step;
                  if (r_sent != {CNT_W{1'b1}}) begin
                     w_sent = r_sent + 1'b1;
                  end
               end
               if (r_cyc == c_RUN_LAST) begin
                  w_state = S_DRAIN;
                  w_cyc   = '0;
               end else begin
                  w_cyc = r_cyc + 1'b1;
               end
            end
            S_DRAIN: begin
               if (r_cyc == c_DRAIN_LAST) begin
                  w_state = S_DONE;
                  w_cyc   = '0;
               end else begin
                  w_cyc = r_cyc + 1'b1;
               end
            end
            S_DONE: begin
               w_start_seq = start;
            end
            default: begin
               w_state       = S_IDLE;
               w_dut_reset_n = 1'b0;
            end
         endcase
      end

      if (w_start_seq) begin
         w_state       = S_HOLD;
         w_cyc         = '0;
         w_sent        = '0;
         w_cnt         = seed[DATA_W-1:0];
         w_lfsr        = w_lfsr_seed;
         w_mode        = mode;
         w_dut_reset_n = 1'b0;
      end

      w_busy = (w_state != S_IDLE) && (w_state != S_DONE);
      w_done = (w_state == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_cyc         <= '0;
         r_mode        <= 1'b0;
         r_cnt         <= '0;
         r_lfsr        <= c_LFSR_INIT;
         r_dut_reset_n <= 1'b0;
         r_data        <= '0;
         r_push        <= 1'b0;
         r_sent        <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_mf          <= '0;
         r_me          <= '0;
         r_vf          <= '0;
         r_ve          <= '0;
         r_df          <= '0;
         r_de          <= '0;
      end else begin
         r_state       <= w_state;
         r_cyc         <= w_cyc;
         r_mode        <= w_mode;
         r_cnt         <= w_cnt;
         r_lfsr        <= w_lfsr;
         r_dut_reset_n <= w_dut_reset_n;
         r_data        <= w_data;
         r_push        <= w_push;
         r_sent        <= w_sent;
         r_busy        <= w_busy;
         r_done        <= w_done;
         r_mf          <= w_mf;
         r_me          <= w_me;
         r_vf          <= w_vf;
         r_ve          <= w_ve;
         r_df          <= w_df;
         r_de          <= w_de;
      end
   end

   // Pops follow the flags combinationally, gated only by registered state.
   assign bus.pop_D = (pop_enable && ((r_state == S_RUN) || (r_state == S_DRAIN))) ?
                      ~bus.almost_empty : '0;

   assign bus.data_in      = r_data;
   assign bus.push_data_in = r_push;
   assign dut_reset_n      = r_dut_reset_n;
   assign sent_count       = r_sent;
   assign busy             = r_busy;
   assign done             = r_done;
   assign umbral_M_full    = r_mf;
   assign umbral_M_empty   = r_me;
   assign umbral_V_full    = r_vf;
   assign umbral_V_empty   = r_ve;
   assign umbral_D_full    = r_df;
   assign umbral_D_empty   = r_de;

endmodule
`default_nettype wire

// File: tb/tb_traffic_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_seq_ctrl
//  Purpose  : Randomised self-checking bench for traffic_seq_ctrl against a
//             cycle-indexed sequence model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_seq_ctrl;
   localparam int DATA_W    = 6;
   localparam int PTR_L     = 5;
   localparam int N_DEST    = 2;
   localparam int HOLD_CYC  = 10;
   localparam int RUN_LEN   = 50;
   localparam int DRAIN_LEN = 50;
   localparam int CNT_W     = 16;

   // Cycle indices counted from the start edge (cycle 0 follows that edge).
   localparam int CFG_CYC     = HOLD_CYC;
   localparam int RUN_FIRST   = HOLD_CYC + 1;
   localparam int DRAIN_FIRST = RUN_FIRST + RUN_LEN;
   localparam int DONE_FIRST  = DRAIN_FIRST + DRAIN_LEN;

   logic clk = 1'b0;
   logic reset, start, abort, mode, pop_enable;
   logic [15:0] seed;
   logic [6*PTR_L-1:0] cfg_all;
   logic [PTR_L-1:0] cfg_M_full, cfg_M_empty, cfg_V_full, cfg_V_empty, cfg_D_full, cfg_D_empty;
   logic [PTR_L-1:0] umbral_M_full, umbral_M_empty, umbral_V_full, umbral_V_empty, umbral_D_full, umbral_D_empty;
   logic dut_reset_n, busy, done;
   logic [CNT_W-1:0] sent_count;

   assign cfg_M_full  = cfg_all[29:25];
   assign cfg_M_empty = cfg_all[24:20];
   assign cfg_V_full  = cfg_all[19:15];
   assign cfg_V_empty = cfg_all[14:10];
   assign cfg_D_full  = cfg_all[9:5];
   assign cfg_D_empty = cfg_all[4:0];

   traffic_seq_ctrl_if #(.DATA_W(DATA_W), .N_DEST(N_DEST)) bus ();

   traffic_seq_ctrl #(
      .DATA_W(DATA_W), .PTR_L(PTR_L), .N_DEST(N_DEST), .HOLD_CYC(HOLD_CYC),
      .RUN_LEN(RUN_LEN), .DRAIN_LEN(DRAIN_LEN), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
      .seed(seed), .pop_enable(pop_enable),
      .cfg_M_full(cfg_M_full), .cfg_M_empty(cfg_M_empty), .cfg_V_full(cfg_V_full),
      .cfg_V_empty(cfg_V_empty), .cfg_D_full(cfg_D_full), .cfg_D_empty(cfg_D_empty),
      .dut_reset_n(dut_reset_n),
      .umbral_M_full(umbral_M_full), .umbral_M_empty(umbral_M_empty),
      .umbral_V_full(umbral_V_full), .umbral_V_empty(umbral_V_empty),
      .umbral_D_full(umbral_D_full), .umbral_D_empty(umbral_D_empty),
      .sent_count(sent_count), .busy(busy), .done(done),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [29:0] exp_umb;
   int          exp_sent;
   logic        m_mode;
   int          m_base;
   int          m_n;
   logic [15:0] m_lfsr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_word(output logic [DATA_W-1:0] w);
      if (m_mode == 1'b0) begin
         w = DATA_W'((m_base + m_n) % (1 << DATA_W));
      end else begin
         w = m_lfsr[DATA_W-1:0];
         m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      end
      m_n++;
   endtask

   function automatic logic [29:0] umb_all();
      return {umbral_M_full, umbral_M_empty, umbral_V_full,
              umbral_V_empty, umbral_D_full, umbral_D_empty};
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_busy"},  32'(busy), 32'd0);
      check({tag, "_done"},  32'(done), 32'd0);
      check({tag, "_rstn"},  32'(dut_reset_n), 32'd0);
      check({tag, "_push"},  32'(bus.push_data_in), 32'd0);
      check({tag, "_data"},  32'(bus.data_in), 32'd0);
      check({tag, "_umb"},   32'(umb_all()), 32'(exp_umb));
      check({tag, "_sent"},  32'(sent_count), 32'(exp_sent));
      pop_enable = 1'b1;
      bus.almost_empty = '0;
      #1;
      check({tag, "_pop"},   32'(bus.pop_D), 32'd0);
   endtask

   // irq_kind: 0 none, 1 reset, 2 abort, applied after the checks of cycle irq_cyc.
   task automatic run_seq(input logic md, input logic [15:0] sd, input logic [29:0] cfg_want,
                          input int pkind, input int irq_kind, input int irq_cyc);
      logic              pz [RUN_LEN];
      logic              exp_push;
      logic [DATA_W-1:0] exp_data;
      logic [N_DEST-1:0] exp_pop;
      for (int r = 0; r < RUN_LEN; r++) begin
         pz[r] = (pkind == 0) ? 1'b0 : (pkind == 1) ? ((r % 3) == 2) : 1'($urandom_range(0, 1));
      end
      start = 1'b1; mode = md; seed = sd; cfg_all = 30'($urandom);
      bus.MAIN_FIFO_pause = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      start = 1'b0;
      m_mode = md; m_base = int'(sd[DATA_W-1:0]); m_n = 0;
      m_lfsr = (sd == 16'h0000) ? 16'hACE1 : sd;
      exp_sent = 0;
      for (int j = 0; j <= DONE_FIRST + 3; j++) begin
         exp_push = (j >= RUN_FIRST + 1) && (j <= DRAIN_FIRST) && !pz[j - RUN_FIRST - 1];
         exp_data = '0;
         if (exp_push) begin
            next_word(exp_data);
            exp_sent++;
         end
         if (j == RUN_FIRST) exp_umb = cfg_want;
         check("push",  32'(bus.push_data_in), 32'(exp_push));
         check("data",  32'(bus.data_in), 32'(exp_data));
         check("sent",  32'(sent_count), 32'(exp_sent));
         check("rstn",  32'(dut_reset_n), 32'(j >= CFG_CYC));
         check("busy",  32'(busy), 32'(j < DONE_FIRST));
         check("done",  32'(done), 32'(j >= DONE_FIRST));
         check("umb",   32'(umb_all()), 32'(exp_umb));
         pop_enable = 1'($urandom_range(0, 1));
         bus.almost_empty = N_DEST'($urandom);
         #1;
         exp_pop = (pop_enable && j >= RUN_FIRST && j < DONE_FIRST) ? ~bus.almost_empty : '0;
         check("pop",   32'(bus.pop_D), 32'(exp_pop));
         if (irq_kind != 0 && j == irq_cyc) begin
            if (irq_kind == 1) reset = 1'b1; else abort = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0; abort = 1'b0;
            if (irq_kind == 1) begin
               exp_umb = '0;
               exp_sent = 0;
               check_idle("after_reset");
            end else begin
               check_idle("after_abort");
            end
            return;
         end
         bus.MAIN_FIFO_pause = (j >= RUN_FIRST && j < DRAIN_FIRST) ? pz[j - RUN_FIRST]
                                                                   : 1'($urandom_range(0, 1));
         cfg_all = (j == CFG_CYC) ? cfg_want : 30'($urandom);
         mode = 1'($urandom_range(0, 1));
         seed = 16'($urandom);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; seed = '0;
      pop_enable = 1'b0; cfg_all = 30'($urandom);
      bus.MAIN_FIFO_pause = 1'b0; bus.almost_empty = '0;
      exp_umb = '0; exp_sent = 0;
      m_mode = 1'b0; m_base = 0; m_n = 0; m_lfsr = 16'hACE1;
      @(posedge clk); @(posedge clk); #1;
      check_idle("reset");
      reset = 1'b0;
      @(posedge clk); #1;
      check_idle("idle");

      run_seq(1'b0, 16'h003E, {5'd3, 5'd1, 5'd15, 5'd1, 5'd3, 5'd1}, 0, 0, 0);
      run_seq(1'b0, 16'h0000, 30'($urandom), 1, 0, 0);
      run_seq(1'b1, 16'h0000, 30'($urandom), 0, 0, 0);
      run_seq(1'b1, 16'h0000, 30'($urandom), 0, 0, 0);
      run_seq(1'b1, 16'($urandom), 30'($urandom), 2, 0, 0);
      run_seq(1'b0, 16'($urandom), 30'($urandom), 2, 1, RUN_FIRST + 20);
      run_seq(1'b1, 16'($urandom), 30'($urandom), 2, 0, 0);
      run_seq(1'b0, 16'($urandom), 30'($urandom), 0, 2, DRAIN_FIRST + 9);
      run_seq(1'b1, 16'($urandom), 30'($urandom), 2, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
